// File: rtl/text_console_writer.sv
// Byte-stream to character-buffer writer with a text cursor.
// Handles printable codes, CR, LF, BS and FF, wraps at COLS, recycles rows
// top-to-bottom and clears each newly entered row.
module text_console_writer #(
  parameter int unsigned COLS           = 60,
  parameter int unsigned ROWS           = 34,
  parameter logic [7:0]  CLEAR_CHAR     = 8'h20,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ena,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [11:0] o_address,
  output logic [7:0]  o_data,
  output logic        o_we,
  output logic [5:0]  o_cursor_col,
  output logic [5:0]  o_cursor_row,
  output logic        o_busy
);

  localparam int unsigned SCREEN_WORDS = ROWS * 64;
  localparam logic [11:0] LAST_WORD    = 12'(SCREEN_WORDS - 1);
  localparam logic [6:0]  COLS_W       = 7'(COLS);
  localparam logic [5:0]  LAST_ROW     = 6'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CLR_LINE   = 2'd1,
    CLR_SCREEN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [5:0]  col_q, col_d;
  logic [5:0]  row_q, row_d;
  logic        we_q, we_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;

  logic        accept_c;
  logic        printable_c;
  logic [6:0]  col_inc_c;
  logic [5:0]  row_inc_c;

  assign accept_c    = i_valid & i_ena & ready_q;
  assign printable_c = (i_data >= 8'h20) && (i_data != 8'h7F);
  assign col_inc_c   = {1'b0, col_q} + 7'd1;
  assign row_inc_c   = (row_q == LAST_ROW) ? 6'd0 : row_q + 6'd1;

  // Next-state, cursor and write-port decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    busy_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (printable_c) begin
            we_d   = 1'b1;
            addr_d = {row_q, col_q};
            data_d = i_data;
            if (col_inc_c == COLS_W) begin
              // Wrap: the character write goes out now, the row clear follows.
              col_d   = 6'd0;
              row_d   = row_inc_c;
              cnt_d   = 12'd0;
              state_d = CLR_LINE;
            end else begin
              col_d = col_inc_c[5:0];
            end
          end else begin
            case (i_data)
              8'h0D: col_d = 6'd0;
              8'h0A: begin
                // First word of the row clear is issued on the accept edge.
                col_d   = 6'd0;
                row_d   = row_inc_c;
                we_d    = 1'b1;
                addr_d  = {row_inc_c, 6'd0};
                data_d  = CLEAR_CHAR;
                busy_d  = 1'b1;
                cnt_d   = 12'd1;
                state_d = CLR_LINE;
              end
              8'h08: begin
                if (col_q != 6'd0) begin
                  col_d  = col_q - 6'd1;
                  we_d   = 1'b1;
                  addr_d = {row_q, col_q - 6'd1};
                  data_d = CLEAR_CHAR;
                end
              end
              8'h0C: begin
                col_d   = 6'd0;
                row_d   = 6'd0;
                we_d    = 1'b1;
                addr_d  = 12'd0;
                data_d  = CLEAR_CHAR;
                busy_d  = 1'b1;
                cnt_d   = 12'd1;
                state_d = CLR_SCREEN;
              end
              default: ;
            endcase
          end
        end
      end

      CLR_LINE: begin
        we_d   = 1'b1;
        addr_d = {row_q, cnt_q[5:0]};
        data_d = CLEAR_CHAR;
        busy_d = 1'b1;
        cnt_d  = cnt_q + 12'd1;
        if (cnt_q[5:0] == 6'd63) begin
          cnt_d   = 12'd0;
          state_d = IDLE;
        end
      end

      CLR_SCREEN: begin
        col_d  = 6'd0;
        row_d  = 6'd0;
        we_d   = 1'b1;
        addr_d = cnt_q;
        data_d = CLEAR_CHAR;
        busy_d = 1'b1;
        cnt_d  = cnt_q + 12'd1;
        if (cnt_q == LAST_WORD) begin
          cnt_d   = 12'd0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Ready only after a full idle cycle, so a clear never overlaps a new byte.
  always_comb begin
    ready_d = (state_q == IDLE) && (state_d == IDLE) && i_ena;
  end

  // State and output registers; reset aborts any clear in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= CLEAR_ON_RESET ? CLR_SCREEN : IDLE;
      cnt_q   <= 12'd0;
      col_q   <= 6'd0;
      row_q   <= 6'd0;
      we_q    <= 1'b0;
      addr_q  <= 12'd0;
      data_q  <= 8'd0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign o_ready      = ready_q;
  assign o_address    = addr_q;
  assign o_data       = data_q;
  assign o_we         = we_q;
  assign o_cursor_col = col_q;
  assign o_cursor_row = row_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Scoreboard bench for text_console_writer: a cursor/screen reference model
// predicts every buffer write (address, data, cycle, cursor, busy).
module tb_text_console_writer;

  localparam int COLS = 60;
  localparam int ROWS = 34;
  localparam logic [7:0] CLR = 8'h20;

  logic        clk;
  logic        rst_n;
  logic        i_ena;
  logic [7:0]  i_data;
  logic        i_valid;
  logic        o_ready;
  logic [11:0] o_address;
  logic [7:0]  o_data;
  logic        o_we;
  logic [5:0]  o_cursor_col;
  logic [5:0]  o_cursor_row;
  logic        o_busy;

  text_console_writer #(
    .COLS(COLS), .ROWS(ROWS), .CLEAR_CHAR(CLR), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ena(i_ena), .i_data(i_data),
    .i_valid(i_valid), .o_ready(o_ready), .o_address(o_address),
    .o_data(o_data), .o_we(o_we), .o_cursor_col(o_cursor_col),
    .o_cursor_row(o_cursor_row), .o_busy(o_busy)
  );

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
    int          cyc;
    logic [5:0]  col;
    logic [5:0]  row;
    logic        busy;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   m_col = 0;
  int   m_row = 0;
  int   last_c0 = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic push(input int a, input int d, input int t, input bit busy);
    exp_t e;
    e.addr = 12'(a);
    e.data = 8'(d);
    e.cyc  = t;
    e.col  = 6'(m_col);
    e.row  = 6'(m_row);
    e.busy = busy;
    q.push_back(e);
  endtask

  task automatic clear_row(input int t);
    for (int i = 0; i < 64; i++) push(m_row * 64 + i, CLR, t + i, 1'b1);
  endtask

  task automatic clear_screen(input int t);
    for (int i = 0; i < ROWS * 64; i++) push(i, CLR, t + i, 1'b1);
  endtask

  // Reference behaviour of one accepted byte in cycle c0 (writes from c0+1).
  task automatic model(input logic [7:0] b, input int c0);
    int t = c0 + 1;
    int oc = m_col;
    int orw = m_row;
    if (b >= 8'h20 && b != 8'h7F) begin
      m_col = m_col + 1;
      if (m_col == COLS) begin
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
        push(orw * 64 + oc, b, t, 1'b0);
        clear_row(t + 1);
      end else begin
        push(orw * 64 + oc, b, t, 1'b0);
      end
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h0A) begin
      m_col = 0;
      m_row = (m_row + 1) % ROWS;
      clear_row(t);
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col = m_col - 1;
        push(m_row * 64 + m_col, CLR, t, 1'b0);
      end
    end else if (b == 8'h0C) begin
      m_col = 0;
      m_row = 0;
      clear_screen(t);
    end
  endtask

  // Present a byte until the handshake completes; called at a negedge.
  task automatic send(input logic [7:0] b);
    int n = 0;
    bit acc = 1'b0;
    int c0 = 0;
    i_data  = b;
    i_valid = 1'b1;
    while (!acc) begin
      c0  = cyc;
      acc = o_ready && i_ena;
      @(posedge clk);
      if (acc) model(b, c0);
      @(negedge clk);
      n++;
      if (!acc && n > 5000) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    i_valid = 1'b0;
    last_c0 = c0;
  endtask

  task automatic expect_ready(input string name, input int exp_cyc);
    int n = 0;
    while (!o_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, cyc, exp_cyc);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((!o_ready || q.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", int'(n < 5000), 1);
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    m_col = 0;
    m_row = 0;
    clear_screen(cyc + 1);
  endtask

  // Monitor: every write strobe must match the head of the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && o_we) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr=%h data=%h cyc=%0d", o_address, o_data, cyc);
        end else begin
          e = q.pop_front();
          if (o_address !== e.addr || o_data !== e.data || cyc != e.cyc ||
              o_cursor_col !== e.col || o_cursor_row !== e.row ||
              o_busy !== e.busy || (e.busy && o_ready !== 1'b0)) begin
            errors++;
            $display("FAIL write got addr=%h data=%h cyc=%0d cur=%0d,%0d busy=%b rdy=%b exp addr=%h data=%h cyc=%0d cur=%0d,%0d busy=%b",
                     o_address, o_data, cyc, o_cursor_row, o_cursor_col, o_busy, o_ready,
                     e.addr, e.data, e.cyc, e.row, e.col, e.busy);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0] b;
    int r;
    rst_n   = 1'b0;
    i_ena   = 1'b1;
    i_valid = 1'b0;
    i_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_we", o_we, 0);
    check("rst_addr", o_address, 0);
    check("rst_data", o_data, 0);
    check("rst_ready", o_ready, 0);
    check("rst_busy", o_busy, 0);
    check("rst_cursor", {o_cursor_row, o_cursor_col}, 0);

    // Power-on clear of the whole visible screen.
    release_reset();
    wait_idle();
    check("por_cursor", {o_cursor_row, o_cursor_col}, 0);

    // Back-to-back "AB".
    send(8'h41);
    send(8'h42);
    check("ab_col", o_cursor_col, 2);
    check("ab_ready", o_ready, 1);

    // Fill row 0 to the wrap point.
    for (int i = 0; i < 58; i++) send(8'(8'h61 + i % 26));
    expect_ready("wrap_ready_cyc", last_c0 + 66);
    check("wrap_cursor", {o_cursor_row, o_cursor_col}, {6'd1, 6'd0});

    // Move to row 33 col 5, then LF wraps to row 0.
    for (int i = 0; i < 32; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h78);
    check("r33_cursor", {o_cursor_row, o_cursor_col}, {6'd33, 6'd5});
    send(8'h0A);
    expect_ready("lf_ready_cyc", last_c0 + 65);
    check("lf_wrap_cursor", {o_cursor_row, o_cursor_col}, 0);
    for (int i = 0; i < 5; i++) send(8'h79);
    send(8'h0D);
    check("cr_col", o_cursor_col, 0);
    check("cr_no_we", o_we, 0);

    // Backspace with and without room.
    for (int i = 0; i < 3; i++) send(8'h7A);
    send(8'h08);
    check("bs_col", o_cursor_col, 2);
    send(8'h0D);
    send(8'h08);
    check("bs0_col", o_cursor_col, 0);
    check("bs0_no_we", o_we, 0);

    // A byte offered while i_ena is low must not be consumed.
    i_ena   = 1'b0;
    i_data  = 8'h51;
    i_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("ena_low_col", o_cursor_col, 0);
    check("ena_low_ready", o_ready, 0);
    i_valid = 1'b0;
    i_ena   = 1'b1;

    // Randomised mix of printables, controls, gaps and enable drops.
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 99);
      if (r < 72) begin
        do b = 8'($urandom_range(32, 255)); while (b == 8'h7F);
      end else if (r < 80) b = 8'h0D;
      else if (r < 86) b = 8'h0A;
      else if (r < 94) b = 8'h08;
      else if (r < 95) b = 8'h0C;
      else if (r < 97) b = 8'h7F;
      else begin
        do b = 8'($urandom_range(0, 31)); while (b inside {8'h08, 8'h0A, 8'h0C, 8'h0D});
      end
      if ($urandom_range(0, 7) == 0) begin
        i_ena   = 1'b0;
        i_data  = 8'h21;
        i_valid = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        i_valid = 1'b0;
        i_ena   = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
      send(b);
    end
    wait_idle();
    check("rand_cursor", {o_cursor_row, o_cursor_col}, {6'(m_row), 6'(m_col)});

    // Reset in the middle of a form-feed clear, at word 100.
    send(8'h0C);
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_we", o_we, 0);
    check("abort_addr", o_address, 0);
    check("abort_data", o_data, 0);
    check("abort_ready", o_ready, 0);
    check("abort_busy", o_busy, 0);
    check("abort_cursor", {o_cursor_row, o_cursor_col}, 0);
    q.delete();
    @(negedge clk);
    check("abort_hold_we", o_we, 0);
    @(negedge clk);
    release_reset();
    wait_idle();
    send(8'h5A);
    @(negedge clk);
    check("scoreboard_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
